mfda_pump_seq: RTL and testbench

MFDA_PUMP_SEQ -- requirements
Module: mfda_pump_seq

---
 rtl/mfda_ctrl_pkg.sv | 34 +++
 rtl/mfda_phase_timer.sv | 42 ++++
 rtl/mfda_pump_seq.sv | 162 ++++++++++++++++
 tb/tb_mfda_pump_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfda_ctrl_pkg.sv
// ============================================================================
// Module   : mfda_ctrl_pkg
// Brief    : Shared types and constants for the microfluidic pump sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mfda_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PUMP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int         PHASES_PER_STROKE = 6;
  localparam logic [2:0] VALVE_CLOSED      = 3'b111;

  // Closed-valve pattern per phase, bit order [2:0] of one pump.
  localparam logic [2:0] PHASE_PAT [PHASES_PER_STROKE] = '{
    3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101
  };

  function automatic logic [2:0] phase_pattern(input logic [2:0] idx);
    logic [2:0] pat;
    pat = VALVE_CLOSED;
    if (idx < 3'(PHASES_PER_STROKE)) pat = PHASE_PAT[idx];
    return pat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mfda_phase_timer.sv
// ============================================================================
// Module   : mfda_phase_timer
// Brief    : Loadable down-counter issuing phase_tick once every len cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfda_phase_timer #(
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [PHASE_W-1:0] len,
  input  logic               en,
  output logic               phase_tick
);

  logic [PHASE_W-1:0] r_len;
  logic [PHASE_W-1:0] r_cnt;
  logic               w_last;

  // Count of 0 is treated like 1 so the counter can never wrap.
  assign w_last     = (r_cnt <= PHASE_W'(1));
  assign phase_tick = en && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_len <= len;
      r_cnt <= len;
    end else if (en) begin
      if (w_last) r_cnt <= r_len;
      else        r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mfda_pump_seq.sv
// ============================================================================
// Module   : mfda_pump_seq
// Brief    : Peristaltic pump sequencer; 6-phase valve stepping per stroke.
//            Define MFDA_PUMP_REVERSE_EN to honour cmd_reverse (withdraw).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfda_pump_seq
  import mfda_ctrl_pkg::*;
#(
  parameter int N_INLETS = 3,
  parameter int STROKE_W = 8,
  parameter int PHASE_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_inlet,
  input  logic [STROKE_W-1:0]   cmd_strokes,
  input  logic                  cmd_reverse,
  input  logic [PHASE_W-1:0]    phase_len,
  input  logic                  abort,
  output logic [3*N_INLETS-1:0] valve_o,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [STROKE_W-1:0]   strokes_left
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_inlet;
  logic [STROKE_W-1:0] r_strokes;
  logic [2:0]          r_phase;
  logic                r_err;

  logic                w_accept;
  logic                w_bad_inlet;
  logic                w_tick;
  logic                w_last_phase;
  logic                w_last_stroke;
  logic                w_timer_en;
  logic [PHASE_W-1:0]  w_len;
  logic [2:0]          w_pat_idx;
  logic [2:0]          w_pat;

  assign w_accept      = cmd_valid && (r_state == ST_IDLE);
  assign w_bad_inlet   = (32'(cmd_inlet) >= N_INLETS);
  assign w_len         = (phase_len == '0) ? PHASE_W'(1) : phase_len;
  assign w_last_phase  = (r_phase == 3'(PHASES_PER_STROKE - 1));
  assign w_last_stroke = (r_strokes == STROKE_W'(1));
  assign w_timer_en    = (r_state == ST_PUMP) || (r_state == ST_SETTLE);

  // Reloads itself on the final pump tick, so SETTLE gets a full phase_len.
  mfda_phase_timer #(
    .PHASE_W (PHASE_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_accept),
    .len        (w_len),
    .en         (w_timer_en),
    .phase_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (w_bad_inlet || (cmd_strokes == '0)) w_state_nxt = ST_DONE;
          else                                    w_state_nxt = ST_PUMP;
        end
      end
      ST_PUMP: begin
        if (abort)                                          w_state_nxt = ST_DONE;
        else if (w_tick && w_last_phase && w_last_stroke)   w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort || w_tick) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inlet   <= '0;
      r_strokes <= '0;
      r_phase   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_inlet   <= cmd_inlet;
            r_strokes <= w_bad_inlet ? '0 : cmd_strokes;
            r_phase   <= '0;
            r_err     <= w_bad_inlet;
          end
        end
        ST_PUMP: begin
          if (abort) begin
            r_err <= 1'b1;
          end else if (w_tick) begin
            if (w_last_phase) begin
              r_phase   <= '0;
              r_strokes <= r_strokes - 1'b1;
            end else begin
              r_phase <= r_phase + 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (abort) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MFDA_PUMP_REVERSE_EN
  logic r_reverse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_reverse <= 1'b0;
    else if (w_accept) r_reverse <= cmd_reverse;
  end

  // Withdraw walks the same table from its last entry backwards.
  assign w_pat_idx = r_reverse ? (3'(PHASES_PER_STROKE - 1) - r_phase) : r_phase;
`else
  logic w_unused_reverse;
  assign w_unused_reverse = cmd_reverse;
  assign w_pat_idx        = r_phase;
`endif

  assign w_pat = phase_pattern(w_pat_idx);

  generate
    for (genvar gi = 0; gi < N_INLETS; gi++) begin : g_pump
      assign valve_o[3*gi +: 3] = ((r_state == ST_PUMP) && (r_inlet == 2'(gi))) ?
                                  w_pat : VALVE_CLOSED;
    end
  endgenerate

  assign cmd_ready    = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE);
  assign err          = done && r_err;
  assign strokes_left = r_strokes;

endmodule

`default_nettype wire

// File: tb/tb_mfda_pump_seq.sv
// ============================================================================
// Module   : tb_mfda_pump_seq
// Brief    : Self-checking bench for mfda_pump_seq (vector table + corner cases).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mfda_pump_seq;

`ifdef MFDA_PUMP_REVERSE_EN
  localparam bit REV_EN = 1'b1;
`else
  localparam bit REV_EN = 1'b0;
`endif
  localparam logic [8:0] ALL_CLOSED = 9'h1ff;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_inlet;
  logic [7:0]  cmd_strokes;
  logic        cmd_reverse;
  logic [15:0] phase_len;
  logic        abort;
  logic [8:0]  valve_o;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  strokes_left;

  always #5 clk = ~clk;

  mfda_pump_seq #(
    .N_INLETS (3),
    .STROKE_W (8),
    .PHASE_W  (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_inlet    (cmd_inlet),
    .cmd_strokes  (cmd_strokes),
    .cmd_reverse  (cmd_reverse),
    .phase_len    (phase_len),
    .abort        (abort),
    .valve_o      (valve_o),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .strokes_left (strokes_left)
  );

  typedef struct {
    logic [8:0] valve;
    logic       done;
    logic       err;
    logic       chk_sl;
    logic [7:0] sl;
  } exp_t;

  typedef struct {
    int inlet;
    int strokes;
    int rev;
    int plen;
    int lat;
    bit eerr;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[7];
  logic [2:0] pat_tab [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one expected record per cycle after accept.
  task automatic push_expect(input int inlet, input int s, input int rev,
                             input int plen, input int lat, input bit eerr);
    int   leff;
    int   idx;
    exp_t e;
    leff = (plen == 0) ? 1 : plen;
    for (int k = 1; k <= lat; k++) begin
      e.valve  = ALL_CLOSED;
      e.done   = (k == lat);
      e.err    = (k == lat) && eerr;
      e.chk_sl = (inlet < 3);
      e.sl     = 8'd0;
      if (inlet < 3 && k <= 6 * s * leff) begin
        idx = ((k - 1) / leff) % 6;
        if (rev != 0 && REV_EN) idx = 5 - idx;
        e.valve[3*inlet +: 3] = pat_tab[idx];
        e.sl = 8'(s - (k - 1) / (6 * leff));
      end
      sb.push_back(e);
    end
  endtask

  task automatic run_checks(input string tag, input bit scramble, input int lat);
    exp_t e;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("%s k%0d valve", tag, k), 32'(valve_o), 32'(e.valve));
      chk($sformatf("%s k%0d done", tag, k), 32'(done), 32'(e.done));
      chk($sformatf("%s k%0d err", tag, k), 32'(err), 32'(e.err));
      chk($sformatf("%s k%0d busy", tag, k), 32'(busy), 32'd1);
      chk($sformatf("%s k%0d ready", tag, k), 32'(cmd_ready), 32'd0);
      if (e.chk_sl) chk($sformatf("%s k%0d strokes_left", tag, k), 32'(strokes_left), 32'(e.sl));
      if (scramble) begin
        cmd_valid   = (k < lat);
        cmd_inlet   = 2'($urandom_range(0, 3));
        cmd_strokes = 8'($urandom);
        cmd_reverse = 1'($urandom);
        phase_len   = 16'($urandom);
      end
    end
  endtask

  task automatic send(input int inlet, input int s, input int rev, input int plen);
    @(negedge clk);
    cmd_inlet   = 2'(inlet);
    cmd_strokes = 8'(s);
    cmd_reverse = 1'(rev);
    phase_len   = 16'(plen);
    cmd_valid   = 1'b1;
    chk("ready before accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, " idle ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle done"}, 32'(done), 32'd0);
    chk({tag, " idle valve"}, 32'(valve_o), 32'(ALL_CLOSED));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1, 2, 0, 4, 53, 1'b0};
    vecs[1] = '{0, 1, 1, 1, 8,  1'b0};
    vecs[2] = '{2, 0, 0, 3, 1,  1'b0};
    vecs[3] = '{3, 5, 0, 2, 1,  1'b1};
    vecs[4] = '{2, 1, 0, 0, 8,  1'b0};
    vecs[5] = '{2, 3, 0, 2, 39, 1'b0};
    vecs[6] = '{0, 1, 1, 3, 22, 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_inlet = '0; cmd_strokes = '0;
    cmd_reverse = 1'b0; phase_len = '0; abort = 1'b0;
    #12;
    chk("reset valve", 32'(valve_o), 32'(ALL_CLOSED));
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset strokes_left", 32'(strokes_left), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("post-reset");

    for (int i = 0; i < 7; i++) begin
      send(vecs[i].inlet, vecs[i].strokes, vecs[i].rev, vecs[i].plen);
      push_expect(vecs[i].inlet, vecs[i].strokes, vecs[i].rev, vecs[i].plen,
                  vecs[i].lat, vecs[i].eerr);
      run_checks($sformatf("vec%0d", i), 1'b1, vecs[i].lat);
      idle_check($sformatf("vec%0d", i));
    end

    // Abort in the third phase of the first stroke.
    send(1, 5, 0, 2);
    repeat (5) @(negedge clk);
    chk("abort pre valve", 32'(valve_o[5:3]), 32'(3'b010));
    chk("abort pre strokes_left", 32'(strokes_left), 32'd5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort valve", 32'(valve_o), 32'(ALL_CLOSED));
    chk("abort done", 32'(done), 32'd1);
    chk("abort err", 32'(err), 32'd1);
    idle_check("abort");

    // Abort while idle is ignored.
    @(negedge clk);
    abort = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle abort busy", 32'(busy), 32'd0);
      chk("idle abort done", 32'(done), 32'd0);
    end
    abort = 1'b0;

    // Abort on the last SETTLE cycle coincides with natural completion.
    send(0, 1, 0, 1);
    repeat (7) @(negedge clk);
    chk("settle valve", 32'(valve_o), 32'(ALL_CLOSED));
    chk("settle busy", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("settle abort done", 32'(done), 32'd1);
    chk("settle abort err", 32'(err), 32'd1);
    idle_check("settle abort");

    // Asynchronous reset in the middle of PUMP.
    send(2, 3, 0, 2);
    repeat (4) @(negedge clk);
    chk("rst pre valve", 32'(valve_o[8:6]), 32'(3'b110));
    #2 rst_n = 1'b0;
    #1;
    chk("rst async valve", 32'(valve_o), 32'(ALL_CLOSED));
    chk("rst async busy", 32'(busy), 32'd0);
    chk("rst async strokes_left", 32'(strokes_left), 32'd0);
    chk("rst async done", 32'(done), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst hold done", 32'(done), 32'd0);
      chk("rst hold valve", 32'(valve_o), 32'(ALL_CLOSED));
    end
    rst_n = 1'b1;
    idle_check("rst release");

    // Back-to-back with cmd_valid held; second command uses phase_len 0.
    @(negedge clk);
    cmd_inlet = 2'd0; cmd_strokes = 8'd1; cmd_reverse = 1'b0; phase_len = 16'd1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_inlet = 2'd1; cmd_strokes = 8'd1; phase_len = 16'd0;
    push_expect(0, 1, 0, 1, 8, 1'b0);
    run_checks("b2b first", 1'b0, 8);
    @(negedge clk);
    chk("b2b gap ready", 32'(cmd_ready), 32'd1);
    chk("b2b gap busy", 32'(busy), 32'd0);
    chk("b2b gap valve", 32'(valve_o), 32'(ALL_CLOSED));
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    push_expect(1, 1, 0, 0, 8, 1'b0);
    run_checks("b2b second", 1'b0, 8);
    idle_check("b2b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
